// File: rtl/multicycle_control_if.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_control_if
// Description : Datapath-facing bundle of the multicycle MIPS main control FSM:
//               opcode/status/memory-ready inputs and the control, status and
//               debug outputs. master = controller side, slave = datapath side.
// Revision    : 1.0  initial release
// ============================================================================
interface multicycle_control_if #(
  parameter int CNT_W = 32
);
  // Datapath / memory status into the controller
  logic [5:0]       opcode;
  logic             zero;
  logic             mem_ready;

  // Datapath control out of the controller
  logic             pc_en;
  logic             iord;
  logic             mem_read;
  logic             mem_write;
  logic             ir_write;
  logic             reg_dst;
  logic             mem_to_reg;
  logic             reg_write;
  logic             alu_src_a;
  logic [1:0]       alu_src_b;
  logic [1:0]       alu_op;
  logic [1:0]       pc_src;

  // Status and debug
  logic             bus_err;
  logic             instr_done;
  logic [CNT_W-1:0] instr_count;
  logic [3:0]       state;

  modport master (
    input  opcode, zero, mem_ready,
    output pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
           reg_write, alu_src_a, alu_src_b, alu_op, pc_src,
           bus_err, instr_done, instr_count, state
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
           reg_write, alu_src_a, alu_src_b, alu_op, pc_src,
           bus_err, instr_done, instr_count, state
  );
endinterface
`default_nettype wire

// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_control
// Description : Multicycle MIPS main control FSM. Sequences FETCH / DECODE /
//               EXEC / MEM / WB over a shared ALU and unified memory, with a
//               ready handshake and optional timeout on every memory request,
//               and counts retired instructions.
//               Build option ILLEGAL_TRAP_EN: unknown opcodes park the FSM in
//               TRAP (state 12) until reset; otherwise they are dropped as NOPs.
// Revision    : 1.0  initial release
// ============================================================================
module multicycle_control #(
  parameter int TIMEOUT = 16,  // memory wait cycles before bus_err; 0 = never
  parameter int TO_W    = 5,   // wait counter width, must hold TIMEOUT
  parameter int CNT_W   = 32   // retired-instruction counter width
) (
  input  wire logic            clk,
  input  wire logic            reset,
  multicycle_control_if.master bus
);

  typedef enum logic [3:0] {
    ST_FETCH  = 4'd0,
    ST_DECODE = 4'd1,
    ST_MEMADR = 4'd2,
    ST_MEMRD  = 4'd3,
    ST_MEMWB  = 4'd4,
    ST_MEMWR  = 4'd5,
    ST_RTEX   = 4'd6,
    ST_RTWB   = 4'd7,
    ST_BRANCH = 4'd8,
    ST_JUMP   = 4'd9,
    ST_IMMEX  = 4'd10,
    ST_IMMWB  = 4'd11,
    ST_TRAP   = 4'd12
  } stateT;

  localparam logic [5:0] c_opR    = 6'b000000;
  localparam logic [5:0] c_opBeq  = 6'b000100;
  localparam logic [5:0] c_opBne  = 6'b000101;
  localparam logic [5:0] c_opLw   = 6'b100011;
  localparam logic [5:0] c_opSw   = 6'b101011;
  localparam logic [5:0] c_opJ    = 6'b000010;
  localparam logic [5:0] c_opAddi = 6'b001000;
  localparam logic [5:0] c_opOri  = 6'b001101;
  localparam logic [5:0] c_opLui  = 6'b001111;

  // Last wait count before a held request is abandoned
  localparam logic [TO_W-1:0] c_toLast = TO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  stateT            r_state;
  stateT            w_nextState;
  logic [TO_W-1:0]  r_waitCnt;
  logic [CNT_W-1:0] r_instrCount;

  logic       w_memReq;
  logic       w_timeout;
  logic       w_waitInc;
  logic       w_retire;
  logic       w_pcEn;
  logic       w_iord;
  logic       w_memRead;
  logic       w_memWrite;
  logic       w_irWrite;
  logic       w_regDst;
  logic       w_memToReg;
  logic       w_regWrite;
  logic       w_aluSrcA;
  logic [1:0] w_aluSrcB;
  logic [1:0] w_aluOp;
  logic [1:0] w_pcSrc;
  logic       w_busErr;

  // Memory request tracking: a request that sits unanswered for TIMEOUT cycles times out
  always_comb begin
    w_memReq  = (r_state == ST_FETCH) || (r_state == ST_MEMRD) || (r_state == ST_MEMWR);
    w_timeout = 1'b0;
    w_waitInc = 1'b0;
    if (TIMEOUT != 0) begin
      w_timeout = w_memReq && !bus.mem_ready && (r_waitCnt == c_toLast);
      w_waitInc = w_memReq && !bus.mem_ready && !w_timeout;
    end
  end

  // State register, wait counter and retired-instruction counter
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_FETCH;
      r_waitCnt    <= '0;
      r_instrCount <= '0;
    end else begin
      r_state   <= w_nextState;
      // Any cycle that is not a still-pending request restarts the wait window,
      // so a timed-out FETCH retries with a full window.
      r_waitCnt <= w_waitInc ? r_waitCnt + TO_W'(1) : '0;
      if (w_retire) begin
        r_instrCount <= r_instrCount + CNT_W'(1);
      end
    end
  end

  // Next-state and control decode; mem_ready wins over a coincident timeout
  always_comb begin
    w_nextState = r_state;
    w_retire    = 1'b0;
    w_pcEn      = 1'b0;
    w_iord      = 1'b0;
    w_memRead   = 1'b0;
    w_memWrite  = 1'b0;
    w_irWrite   = 1'b0;
    w_regDst    = 1'b0;
    w_memToReg  = 1'b0;
    w_regWrite  = 1'b0;
    w_aluSrcA   = 1'b0;
    w_aluSrcB   = 2'b00;
    w_aluOp     = 2'b00;
    w_pcSrc     = 2'b00;
    w_busErr    = 1'b0;
    case (r_state)
      ST_FETCH: begin
        w_memRead = 1'b1;
        w_aluSrcB = 2'b01;
        w_aluOp   = 2'b10;
        if (bus.mem_ready) begin
          w_pcEn      = 1'b1;
          w_irWrite   = 1'b1;
          w_nextState = ST_DECODE;
        end else if (w_timeout) begin
          w_busErr    = 1'b1;
          w_nextState = ST_FETCH;
        end
      end
      ST_DECODE: begin
        w_aluSrcB = 2'b11;
        w_aluOp   = 2'b10;
        case (bus.opcode)
          c_opLw, c_opSw:              w_nextState = ST_MEMADR;
          c_opR:                       w_nextState = ST_RTEX;
          c_opBeq, c_opBne:            w_nextState = ST_BRANCH;
          c_opJ:                       w_nextState = ST_JUMP;
          c_opAddi, c_opOri, c_opLui:  w_nextState = ST_IMMEX;
`ifdef ILLEGAL_TRAP_EN
          default:                     w_nextState = ST_TRAP;
`else
          default:                     w_nextState = ST_FETCH;
`endif
        endcase
      end
      ST_MEMADR: begin
        w_aluSrcA   = 1'b1;
        w_aluSrcB   = 2'b10;
        w_aluOp     = 2'b10;
        w_nextState = (bus.opcode == c_opSw) ? ST_MEMWR : ST_MEMRD;
      end
      ST_MEMRD: begin
        w_memRead = 1'b1;
        w_iord    = 1'b1;
        if (bus.mem_ready) begin
          w_nextState = ST_MEMWB;
        end else if (w_timeout) begin
          w_busErr    = 1'b1;
          w_nextState = ST_FETCH;
        end
      end
      ST_MEMWB: begin
        w_regWrite  = 1'b1;
        w_memToReg  = 1'b1;
        w_retire    = 1'b1;
        w_nextState = ST_FETCH;
      end
      ST_MEMWR: begin
        w_memWrite = 1'b1;
        w_iord     = 1'b1;
        if (bus.mem_ready) begin
          w_retire    = 1'b1;
          w_nextState = ST_FETCH;
        end else if (w_timeout) begin
          w_busErr    = 1'b1;
          w_nextState = ST_FETCH;
        end
      end
      ST_RTEX: begin
        w_aluSrcA   = 1'b1;
        w_nextState = ST_RTWB;
      end
      ST_RTWB: begin
        w_regWrite  = 1'b1;
        w_regDst    = 1'b1;
        w_retire    = 1'b1;
        w_nextState = ST_FETCH;
      end
      ST_IMMEX: begin
        w_aluSrcA   = 1'b1;
        w_aluSrcB   = 2'b10;
        w_aluOp     = 2'b11;
        w_nextState = ST_IMMWB;
      end
      ST_IMMWB: begin
        w_regWrite  = 1'b1;
        w_retire    = 1'b1;
        w_nextState = ST_FETCH;
      end
      ST_BRANCH: begin
        w_aluSrcA   = 1'b1;
        w_aluOp     = 2'b01;
        w_pcSrc     = 2'b01;
        w_pcEn      = (bus.opcode == c_opBne) ? ~bus.zero : bus.zero;
        w_retire    = 1'b1;
        w_nextState = ST_FETCH;
      end
      ST_JUMP: begin
        w_pcSrc     = 2'b10;
        w_pcEn      = 1'b1;
        w_retire    = 1'b1;
        w_nextState = ST_FETCH;
      end
`ifdef ILLEGAL_TRAP_EN
      ST_TRAP: begin
        w_nextState = ST_TRAP;
      end
`endif
      default: begin
        w_nextState = ST_FETCH;
      end
    endcase
  end

  // Every output is forced low while reset is held so an aborted access issues nothing
  assign bus.pc_en       = w_pcEn     & ~reset;
  assign bus.iord        = w_iord     & ~reset;
  assign bus.mem_read    = w_memRead  & ~reset;
  assign bus.mem_write   = w_memWrite & ~reset;
  assign bus.ir_write    = w_irWrite  & ~reset;
  assign bus.reg_dst     = w_regDst   & ~reset;
  assign bus.mem_to_reg  = w_memToReg & ~reset;
  assign bus.reg_write   = w_regWrite & ~reset;
  assign bus.alu_src_a   = w_aluSrcA  & ~reset;
  assign bus.alu_src_b   = reset ? 2'b00 : w_aluSrcB;
  assign bus.alu_op      = reset ? 2'b00 : w_aluOp;
  assign bus.pc_src      = reset ? 2'b00 : w_pcSrc;
  assign bus.bus_err     = w_busErr   & ~reset;
  assign bus.instr_done  = w_retire   & ~reset;
  assign bus.instr_count = reset ? '0 : r_instrCount;
  assign bus.state       = reset ? 4'd0 : r_state;

endmodule
`default_nettype wire
